// File: rtl/filter_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : filter_bank_sequencer
// Purpose  : Time-multiplexed controller for a three-band FIR equalizer.
//            Stores each accepted sample in a circular delay buffer and
//            steps one shared multiplier across every tap of the low, mid
//            and high coefficient sets. The three band sums are then
//            presented to the downstream stage behind a valid/ready
//            handshake.
// Ports    : clk, reset          - clock and synchronous active-high reset
//            clear_req           - zero the delay buffer (honoured in IDLE)
//            in_valid/in_ready   - input sample handshake, audio_in = sample
//            coeff_band/idx      - coefficient address driven during MAC
//            coeff_data          - signed coefficient returned for that address
//            out_valid/out_ready - band result handshake
//            low/mid/high_band   - signed band results
//            busy                - high while clearing or accumulating
// Revision : 1.0 - initial release
// ============================================================================
module filter_bank_sequencer #(
  parameter  int FILTER_SIZE      = 100,
  parameter  int AUDIO_DEPTH      = 16,
  parameter  int FILTER_PRECISION = 512,
  parameter  int IN_SHIFT         = 5,
  localparam int NTAPS            = FILTER_SIZE + 1,
  localparam int IDX_W            = $clog2(NTAPS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_req,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [AUDIO_DEPTH-1:0] audio_in,
  output logic [1:0]                    coeff_band,
  output logic [IDX_W-1:0]              coeff_idx,
  input  logic signed [AUDIO_DEPTH-1:0] coeff_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [AUDIO_DEPTH-1:0] low_band,
  output logic signed [AUDIO_DEPTH-1:0] mid_band,
  output logic signed [AUDIO_DEPTH-1:0] high_band,
  output logic                          busy
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]               C_LAST = IDX_W'(FILTER_SIZE);
  localparam logic [IDX_W-1:0]               C_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]               C_NTAP = IDX_W'(NTAPS);
  localparam logic signed [2*AUDIO_DEPTH-1:0] C_PREC = (2*AUDIO_DEPTH)'(FILTER_PRECISION);

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              clr_cnt_q, clr_cnt_d;
  logic [IDX_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]              tap_q, tap_d;
  logic [1:0]                    band_q, band_d;
  logic signed [AUDIO_DEPTH-1:0] acc_q [3];
  logic signed [AUDIO_DEPTH-1:0] acc_d [3];
  logic signed [AUDIO_DEPTH-1:0] low_q, low_d, mid_q, mid_d, high_q, high_d;
  logic                          out_valid_q, out_valid_d;

  // Delay line; contents are defined by the CLEAR pass that follows reset.
  logic signed [AUDIO_DEPTH-1:0] mem_q [NTAPS];
  logic                          mem_we;
  logic [IDX_W-1:0]              mem_waddr;
  logic signed [AUDIO_DEPTH-1:0] mem_wdata;

  logic [IDX_W-1:0]                wr_ptr_inc;
  logic [IDX_W-1:0]                rd_idx;
  logic signed [AUDIO_DEPTH-1:0]   x_w;
  logic signed [2*AUDIO_DEPTH-1:0] prod_w;
  logic signed [2*AUDIO_DEPTH-1:0] quot_w;
  logic signed [AUDIO_DEPTH-1:0]   term_w;

  assign wr_ptr_inc = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + C_ONE;
  // Modular subtract; the add of NTAPS may overflow IDX_W bits but the
  // final in-range result is still exact modulo 2**IDX_W.
  assign rd_idx     = (wr_ptr_q >= tap_q) ? wr_ptr_q - tap_q
                                          : C_NTAP + wr_ptr_q - tap_q;
  assign x_w        = mem_q[rd_idx];
  assign prod_w     = coeff_data * x_w;
  // Signed division truncates toward zero, unlike an arithmetic shift.
  assign quot_w     = prod_w / C_PREC;
  assign term_w     = quot_w[AUDIO_DEPTH-1:0];

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_CLEAR) || (state_q == S_MAC);
  assign coeff_band = (state_q == S_MAC) ? band_q : 2'd0;
  assign coeff_idx  = (state_q == S_MAC) ? C_LAST - tap_q : '0;
  assign out_valid  = out_valid_q;
  assign low_band   = low_q;
  assign mid_band   = mid_q;
  assign high_band  = high_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    band_d      = band_q;
    for (int b = 0; b < 3; b++) acc_d[b] = acc_q[b];
    low_d       = low_q;
    mid_d       = mid_q;
    high_d      = high_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr_cnt_q == C_LAST) begin
          clr_cnt_d = '0;
          wr_ptr_d  = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + C_ONE;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          wr_ptr_d  = wr_ptr_inc;
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_inc;
          mem_wdata = audio_in >>> IN_SHIFT;
          for (int b = 0; b < 3; b++) acc_d[b] = '0;
          band_d    = 2'd0;
          tap_d     = '0;
          state_d   = S_MAC;
        end else if (clear_req) begin
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_MAC: begin
        for (int b = 0; b < 3; b++) begin
          if (band_q == 2'(b)) acc_d[b] = acc_q[b] + term_w;
        end
        if (tap_q == C_LAST) begin
          tap_d = '0;
          if (band_q == 2'd2) begin
            // acc_d already holds the final high-band term.
            low_d       = acc_d[0];
            mid_d       = acc_d[1];
            high_d      = acc_d[2];
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            band_d = band_q + 2'd1;
          end
        end else begin
          tap_d = tap_q + C_ONE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      band_q      <= 2'd0;
      for (int b = 0; b < 3; b++) acc_q[b] <= '0;
      low_q       <= '0;
      mid_q       <= '0;
      high_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_q       <= tap_d;
      band_q      <= band_d;
      for (int b = 0; b < 3; b++) acc_q[b] <= acc_d[b];
      low_q       <= low_d;
      mid_q       <= mid_d;
      high_q      <= high_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_bank_sequencer
// Purpose  : Self-checking bench for filter_bank_sequencer. A coefficient
//            table answers the DUT's coefficient reads; a sample-history
//            reference model predicts each band triple, which is queued and
//            popped by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_bank_sequencer;
  localparam int FS   = 100;
  localparam int NT   = FS + 1;
  localparam int PREC = 512;
  localparam int SH   = 5;
  localparam int IW   = $clog2(NT);
  localparam int LAT  = 3 * NT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_req = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [15:0] audio_in = '0;
  logic in_ready, out_valid, busy;
  logic [1:0] coeff_band;
  logic [IW-1:0] coeff_idx;
  logic signed [15:0] coeff_data, low_band, mid_band, high_band;

  int coef_tab [3][NT];
  int hist [NT];          // hist[i] = i-th most recent stored sample
  logic [47:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  filter_bank_sequencer dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .in_valid(in_valid),
    .in_ready(in_ready), .audio_in(audio_in), .coeff_band(coeff_band),
    .coeff_idx(coeff_idx), .coeff_data(coeff_data), .out_valid(out_valid),
    .out_ready(out_ready), .low_band(low_band), .mid_band(mid_band),
    .high_band(high_band), .busy(busy)
  );

  always_comb begin
    coeff_data = '0;
    if (int'(coeff_band) < 3 && int'(coeff_idx) < NT)
      coeff_data = 16'(coef_tab[int'(coeff_band)][int'(coeff_idx)]);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void set_table(input int mode);
    logic signed [15:0] r;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NT; i++) begin
        r = 16'($urandom);
        case (mode)
          1: coef_tab[b][i] = (b == 0 && i == FS) ? 512 : 0;
          2: coef_tab[b][i] = (b == 1) ? 512 : 0;
          3: coef_tab[b][i] = (b == 0 && i == FS) ? 1 : 0;
          4: coef_tab[b][i] = int'(r);
          default: coef_tab[b][i] = 0;
        endcase
      end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NT; i++) hist[i] = 0;
  endfunction

  // Band k = sum over history of trunc0(coef[k][FS-i] * hist[i] / PREC),
  // each term and the sum reduced to 16-bit two's complement.
  function automatic void model_accept(input logic signed [15:0] s);
    logic signed [15:0] x, t;
    int p, q;
    int sum [3];
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    x = s >>> SH;
    hist[0] = int'(x);
    for (int b = 0; b < 3; b++) begin
      sum[b] = 0;
      for (int i = 0; i < NT; i++) begin
        p = coef_tab[b][FS-i] * hist[i];
        q = p / PREC;
        t = 16'(q);
        sum[b] += int'(t);
      end
    end
    exp_q.push_back({16'(sum[0]), 16'(sum[1]), 16'(sum[2])});
  endfunction

  // Output monitor: scores every transfer the DUT actually completes.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got low=%0d with no pending expectation", low_band);
        end else begin
          e = exp_q.pop_front();
          check("sb_low",  longint'(low_band),  longint'($signed(e[47:32])));
          check("sb_mid",  longint'(mid_band),  longint'($signed(e[31:16])));
          check("sb_high", longint'(high_band), longint'($signed(e[15:0])));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    int nb = 0;
    while (!in_ready && n < 300) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check(name, n, NT);
    check({name, "_busy"}, nb, NT);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 1000) begin tick(); n++; end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_in_ready: got in_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic accept(input logic signed [15:0] s);
    wait_idle();
    in_valid = 1'b1;
    audio_in = s;
    @(posedge clk);
    model_accept(s);
    #1;
    in_valid = 1'b0;
    audio_in = 16'($urandom);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 400) begin tick(); n++; end
    check("latency", n, LAT);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    check("hs_out_valid", longint'(out_valid), 0);
    check("hs_in_ready", longint'(in_ready), 1);
  endtask

  task automatic send(input logic signed [15:0] s, input int stall);
    accept(s);
    out_ready = (stall == 0);
    wait_out();
    repeat (stall) tick();
    finish_out();
  endtask

  task automatic do_clear();
    wait_idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_clear();
    count_clear("clear_req_len");
  endtask

  initial begin
    int bad;
    logic signed [15:0] h_low, h_mid, h_high;
    model_clear();
    set_table(0);

    // Reset state and post-reset buffer clear.
    repeat (3) tick();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_low", longint'(low_band), 0);
    check("rst_mid", longint'(mid_band), 0);
    check("rst_high", longint'(high_band), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    reset = 1'b0;
    count_clear("reset_clear_len");

    // Single impulse tap on the low band.
    set_table(1);
    send(16'sd32000, 0);
    check("impulse_low", longint'(low_band), 1000);
    check("impulse_mid", longint'(mid_band), 0);
    send(16'sd0, 0);
    check("impulse_low_next", longint'(low_band), 0);

    // Mid band flat coefficients: ramp, then oldest entry overwritten.
    do_clear();
    set_table(2);
    for (int k = 1; k <= NT; k++) begin
      send(16'sd3200, 0);
      check("mid_ramp", longint'(mid_band), 100 * k);
    end
    send(16'sd0, 0);
    check("mid_wrap", longint'(mid_band), 10000);

    // Truncation toward zero for negative products.
    do_clear();
    set_table(3);
    send(-16'sd32000, 0);
    check("trunc_neg", longint'(low_band), -1);
    send(16'sd32000, 0);
    check("trunc_pos", longint'(low_band), 1);

    // Output back-pressure with in_valid toggling.
    set_table(4);
    accept(16'($urandom));
    out_ready = 1'b0;
    wait_out();
    h_low = low_band; h_mid = mid_band; h_high = high_band;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      in_valid = ~in_valid;
      audio_in = 16'($urandom);
      tick();
      if (!out_valid || in_ready || low_band != h_low || mid_band != h_mid || high_band != h_high)
        bad++;
    end
    in_valid = 1'b0;
    check("hold_stable", bad, 0);
    finish_out();

    // Reset in the middle of MAC: nothing stale may survive.
    set_table(1);
    accept(16'sd32000);
    repeat (150) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_low", longint'(low_band), 0);
    count_clear("abort_clear_len");
    send(16'sd32000, 0);
    check("after_reset_low", longint'(low_band), 1000);

    // Same via clear_req after polluting the buffer.
    set_table(4);
    send(16'($urandom), 1);
    send(16'($urandom), 0);
    do_clear();
    set_table(1);
    send(16'sd32000, 0);
    check("after_clear_low", longint'(low_band), 1000);

    // Randomized traffic with random coefficients, stalls and clears.
    for (int t = 0; t < 25; t++) begin
      set_table(4);
      if ($urandom_range(0, 5) == 0) do_clear();
      send(16'($urandom), int'($urandom_range(0, 4)));
    end

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
